// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: parallel operand pair to LSB-first aligned bit streams with vld/last
module serial_operand_serializer #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [W-1:0]  up_a,
    input  logic [W-1:0]  up_b,
    input  logic [LW-1:0] up_len,
    input  logic          stall,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last
);
    logic          busy;
    logic [W-1:0]  sa, sb;
    logic [LW-1:0] cnt;
    logic [LW-1:0] eff_len;
    logic          accept;

    // output decode and handshake; the final bit frees the slot so pairs stream back to back
    always_comb begin
        eff_len = (up_len == '0 || up_len > LW'(W)) ? LW'(W) : up_len;
        vld     = busy && !stall;
        a       = vld && sa[0];
        b       = vld && sb[0];
        last    = vld && cnt == LW'(1);
        up_rdy  = !rst && (!busy || last);
        accept  = up_vld && up_rdy;
    end

    // load on accept, shift out one bit per vld cycle, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
        end else if (accept) begin
            busy <= 1'b1;
            sa   <= up_a;
            sb   <= up_b;
            cnt  <= eff_len;
        end else if (vld) begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            cnt  <= cnt - LW'(1);
            busy <= !last;
        end
    end
endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Upstream feeder for the serial bit-stream adder stage. Accepts a pair of parallel operands with a valid/ready handshake and emits them LSB-first as two aligned one-bit streams with per-bit `vld` and an end-of-operand `last` marker. Supports a per-transaction operand length and a `stall` input that inserts bubbles (`vld` low) without losing bits. Outputs connect directly to the adder's `vld`, `a`, `b`, `last` inputs.

## Interface

Parameters:
- `W`, default 8: maximum operand width in bits (W >= 2).
- `LW`, default `$clog2(W+1)`: width of the length field.

Ports:
- `clk` input 1: clock. One clock domain; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `up_vld` input 1: upstream operand pair valid.
- `up_rdy` output 1: block can accept an operand pair this cycle.
- `up_a` input W: operand A, parallel.
- `up_b` input W: operand B, parallel.
- `up_len` input LW: number of bits to emit, 1..W. Values 0 or >W are treated as W.
- `stall` input 1: bubble request. While high, no bit is emitted and the bit position holds.
- `vld` output 1: a serial bit is present on `a`/`b` this cycle.
- `a` output 1: current bit of A. Driven 0 when `vld` = 0.
- `b` output 1: current bit of B. Driven 0 when `vld` = 0.
- `last` output 1: this is the final (MSB-side) bit of the operand. Only high together with `vld`.

## Operation

- State: `busy` flag, A/B shift registers (W bits each), remaining-bit counter `cnt` (LW bits).
- IDLE (`busy` = 0):
  - `up_rdy` = 1.
  - `vld` = `last` = `a` = `b` = 0.
- Accept when `up_vld && up_rdy`:
  - Load `up_a`/`up_b` into the shift registers.
  - Load `cnt` with the effective length (0 or >W becomes W).
  - Set `busy`.
- SHIFT (`busy` = 1):
  - `vld` = `!stall`.
  - `a`/`b` = shift-register bit 0, gated by `vld`.
  - `last` = `vld && cnt == 1`.
  - On each cycle with `vld` = 1: both registers shift right by one (zero fill) and `cnt` decrements.
  - On each cycle with `stall` = 1: registers and `cnt` hold.
- Completion: on the cycle with `vld && last`:
  - `busy` clears, unless a new pair is accepted in the same cycle.
  - If a new pair is accepted in that cycle, it loads and `busy` stays 1.
- `up_rdy` = `!rst && (!busy || (vld && last))`. This gives back-to-back operands with no idle cycle.
- `stall` in IDLE has no effect; acceptance is not blocked by `stall` in IDLE.
- `stall` high on the final bit: `last` is deferred with that bit, and `up_rdy` stays 0 until the bit actually goes out.
- Bits of `up_a`/`up_b` above the effective length are ignored and never emitted.

## Timing

- Reset (`rst` = 1 at a clock edge):
  - Afterwards: `busy` = 0, `cnt` = 0, shift registers = 0, so `vld` = `last` = `a` = `b` = 0.
  - `up_rdy` = 0 while `rst` is high, 1 from the first cycle after reset release.
- Reset mid-operation:
  - The in-flight operand is discarded.
  - No `last` is emitted for it.
  - Downstream carry is cleared by the same `rst`.
- Latency: a pair accepted at edge k has bit 0 valid in the cycle after edge k.
- With no stalls, an operand of length L occupies exactly L consecutive `vld` cycles.
- Throughput: one bit per cycle. N operands with no stalls and `up_vld` held high produce N·L consecutive `vld` cycles.
- `vld`, `a`, `b`, `last` are combinational from registers and `stall` only. There is no path from `up_*` to the outputs.
- L = 1: the first and only bit carries `vld` = `last` = 1. `up_rdy` is high in that same cycle.

## Test plan

- Reset, then W=8, L=8, A=0x5A, B=0x3C, no stall -> `vld` high 8 cycles. A bits 0,1,0,1,1,0,1,0. B bits 0,0,1,1,1,1,0,0. `last` only on cycle 8. `up_rdy` 0 during cycles 1–7.
- Back-to-back: pairs (0xFF,0x01,L=8) then (0x03,0x01,L=2) with `up_vld` held -> 10 contiguous `vld` cycles. `last` on cycles 8 and 10. Second pair accepted on the cycle-8 edge. Downstream adder sums 0x00 and 0b00.
- Stall: A=0b1011, B=0b0110, L=4; `stall` high on output cycles 2 and 5 -> `vld` pattern 1,0,1,1,0,1. A bits 1,1,0,1 and B bits 0,1,1,0 in `vld` order. `last` on the 6th cycle only.
- Length edge cases: L=1 with A=1, B=1 -> single cycle with `vld` = `last` = `a` = `b` = 1. Also L=0 with A=0x80 -> treated as 8; `a` = 1 only on the 8th bit together with `last`.
- Reset mid-operation: A=0xF0, L=8, assert `rst` after 3 bits -> the next cycle shows `vld` = 0 and `last` never asserts. A new pair accepted after reset starts from its own bit 0.
- `stall` in IDLE with `up_vld` high -> pair is accepted. Output stays bubbled until `stall` drops, then the first bit is bit 0.
